// File: rtl/byteswap_pipe.sv
// byteswap_pipe: byte-swap / pass-through execute unit, DATA_W in {16,32,48,64}; BYTESWAP_BITREV_EN adds bit reversal (op 4'hc).
// Latency: 2 cycles from accept to out_valid, 1 result per cycle.
// Backpressure: out_ready low holds S2, then S1; in_ready drops combinationally once both are full.
module byteswap_pipe #(
  parameter int         DATA_W  = 64,
  parameter int         CNT_W   = 16,
  parameter logic [3:0] OP_SWAP = 4'he,
  parameter logic [3:0] OP_PASS = 4'hd
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        ALUControl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dst,
  output logic              err,
`ifdef BYTESWAP_BITREV_EN
  output logic              bitrev_seen,
`endif
  output logic [CNT_W-1:0]  op_count
);

  typedef struct packed {
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] imm;
    logic [3:0]        op;
  } s1_t;

  s1_t               s1_q;
  logic              s1_valid, s2_valid, s1_adv, s2_adv;
  logic [DATA_W-1:0] r16, r32, r64, dst_d;
  logic [6:0]        g;
  logic              g_legal, err_d;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Reversed candidates per granule; granules wider than DATA_W are never legal.
  always_comb begin
    r16 = '0;
    for (int i = 0; i < 2; i++) r16[i*8 +: 8] = s1_q.src[(1-i)*8 +: 8];
  end

  if (DATA_W >= 32) begin : g_r32
    always_comb begin
      r32 = '0;
      for (int i = 0; i < 4; i++) r32[i*8 +: 8] = s1_q.src[(3-i)*8 +: 8];
    end
  end else begin : g_no_r32
    assign r32 = '0;
  end

  if (DATA_W >= 64) begin : g_r64
    always_comb begin
      r64 = '0;
      for (int i = 0; i < 8; i++) r64[i*8 +: 8] = s1_q.src[(7-i)*8 +: 8];
    end
  end else begin : g_no_r64
    assign r64 = '0;
  end

`ifdef BYTESWAP_BITREV_EN
  localparam logic [3:0] OP_BITREV = 4'hc;
  logic [DATA_W-1:0] b16, b32, b64;
  logic              bitrev_d, s2_bitrev;

  always_comb begin
    b16 = '0;
    for (int i = 0; i < 16; i++) b16[i] = s1_q.src[15-i];
  end

  if (DATA_W >= 32) begin : g_b32
    always_comb begin
      b32 = '0;
      for (int i = 0; i < 32; i++) b32[i] = s1_q.src[31-i];
    end
  end else begin : g_no_b32
    assign b32 = '0;
  end

  if (DATA_W >= 64) begin : g_b64
    always_comb begin
      b64 = '0;
      for (int i = 0; i < 64; i++) b64[i] = s1_q.src[63-i];
    end
  end else begin : g_no_b64
    assign b64 = '0;
  end
`endif

  // Only imm[6:0] selects the granule; any higher bit set makes the request illegal.
  always_comb begin
    g       = s1_q.imm[6:0];
    g_legal = ((s1_q.imm >> 7) == '0) &&
              ((g == 7'd16) || (g == 7'd32 && DATA_W >= 32) || (g == 7'd64 && DATA_W >= 64));
    dst_d   = s1_q.src;
    err_d   = 1'b1;
`ifdef BYTESWAP_BITREV_EN
    bitrev_d = 1'b0;
`endif
    if (s1_q.op == OP_PASS) begin
      err_d = 1'b0;
    end else if (s1_q.op == OP_SWAP && g_legal) begin
      err_d = 1'b0;
      dst_d = (g == 7'd16) ? r16 : (g == 7'd32) ? r32 : r64;
    end
`ifdef BYTESWAP_BITREV_EN
    else if (s1_q.op == OP_BITREV && g_legal) begin
      err_d    = 1'b0;
      bitrev_d = 1'b1;
      dst_d    = (g == 7'd16) ? b16 : (g == 7'd32) ? b32 : b64;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      dst      <= '0;
      err      <= 1'b0;
      op_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= {src, imm, ALUControl};
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          dst <= dst_d;
          err <= err_d;
        end
      end
      if (out_valid && out_ready) op_count <= op_count + CNT_W'(1);
    end
  end

`ifdef BYTESWAP_BITREV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_bitrev   <= 1'b0;
      bitrev_seen <= 1'b0;
    end else begin
      if (s2_adv && s1_valid) s2_bitrev <= bitrev_d;
      if (out_valid && out_ready && s2_bitrev) bitrev_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/byteswap_pipe.md
Name: byteswap_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width byteswap32/byteswap64 ALU blocks.
- One instance covers any DATA_W that is a multiple of 16, up to 64.
- Adds a valid/ready handshake, a two-stage registered pipeline with stall support, illegal-immediate detection and a completed-operation counter.
- Sits in the execute path as a multi-cycle ALU unit, fed by the issue stage and drained by writeback.

Parameters:
- DATA_W, 64, operand/result width; legal values 16, 32, 48, 64.
- CNT_W, 16, width of op_count.
- OP_SWAP, 4'he, ALUControl code for byte swap.
- OP_PASS, 4'hd, ALUControl code for pass-through.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- src  in  DATA_W  operand
- imm  in  DATA_W  swap granularity in bits (16/32/64)
- ALUControl  in  4  operation select
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- dst  out  DATA_W  result
- err  out  1  result flagged illegal (qualified by out_valid)
- op_count  out  CNT_W  number of results handed off

Behaviour:
- Reset: one clock, synchronous, active-high; all signals are sampled on the rising edge of clk.
- Reset values: out_valid=0, dst=0, err=0, op_count=0, all internal valids=0. in_ready=1 in the first cycle after reset release.
- Pipeline stage S1: registers src, imm and ALUControl, and decodes them.
- Pipeline stage S2: registers dst and err.
- Latency: exactly 2 cycles from an accepted request to out_valid when unstalled. Throughput is 1 per cycle.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational path from out_ready is allowed)
- Stall: while out_valid=1 and out_ready=0, dst and err hold stable. No request is lost or duplicated, and results stay in issue order.
- OP_SWAP with imm=G, where G ∈ {16,32,64} and G ≤ DATA_W:
  - dst[G-1:0] = byte-reverse of src[G-1:0]
  - dst[DATA_W-1:G] = 0
  - err=0
- OP_PASS: dst = src for any imm; err=0.
- Illegal SWAP: imm not in {16,32,64}, or imm > DATA_W → dst = src, err=1.
- Any other ALUControl value → dst = src, err=1.
- Only imm[6:0] is decoded. Any nonzero imm[DATA_W-1:7] makes the request illegal (err=1, dst=src).
- op_count: increments by 1 on each cycle with out_valid & out_ready, including results with err=1. Wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: in-flight requests are discarded, out_valid drops the following cycle, op_count clears. A request presented in the same cycle as rst is not accepted.
- Simultaneous events: accept and handoff in the same cycle is legal. A full pipeline with out_ready=1 still accepts a new request in that cycle.

Optional Feature:
- Macro: BYTESWAP_BITREV_EN.
- When defined:
  - ALUControl 4'hc selects bit reversal of src[G-1:0], upper bits zeroed, same legality rules as OP_SWAP.
  - Adds output bitrev_seen (1 bit, reset 0). It is sticky high after the first bit-reverse result is handed off, and cleared only by rst.
- When undefined:
  - 4'hc is treated as an unknown op (dst=src, err=1).
  - The bitrev_seen port does not exist.

Test Plan:
- DATA_W=32, src=32'h12345678, SWAP, imm=16 → dst=32'h00007856; imm=32 → dst=32'h78563412. Both with err=0 and latency 2.
- DATA_W=64, src=64'h0123456789ABCDEF, SWAP:
  - imm=64 → 64'hEFCDAB8967452301
  - imm=32 → 64'h00000000EFCDAB89
  - imm=16 → 64'h000000000000EFCD
  - PASS with any imm → dst=src
- DATA_W=32, SWAP imm=64 → err=1, dst=src. imm=24 → err=1. ALUControl=4'h3 → err=1. op_count advances by 3.
- Back-to-back stream of 8 requests with out_ready held low for cycles 3–5:
  - in_ready deasserts once S1 and S2 are both full.
  - All 8 results arrive in order, none dropped or duplicated.
  - dst holds stable during the stall; op_count=8 at the end.
- rst asserted for one cycle with 2 requests in flight → out_valid=0 the next cycle, op_count=0, no stale result emerges afterwards.
- BYTESWAP_BITREV_EN defined, DATA_W=32, ALUControl=4'hc, imm=32, src=32'h00000001 → dst=32'h80000000, and bitrev_seen rises after the handoff.
